// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute-stage pipeline and the
// iterative multiply/divide unit. The pipeline is the master; the unit is
// the slave.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, req_valid, funct3, rs1_data, rs2_data, resp_ready,
        input  req_ready, resp_valid, result, busy
    );

    modport slave (
        input  flush, req_valid, funct3, rs1_data, rs2_data, resp_ready,
        output req_ready, resp_valid, result, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One operation in flight: radix-2
// shift-add multiply and restoring divide on operand magnitudes, with sign
// correction and half selection applied in a single FIXUP cycle. Division
// by zero and signed overflow skip the iterations entirely.
module muldiv_unit #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } muldiv_funct3_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    // Control state and registered handshake outputs.
    state_t state_q;
    logic   req_ready_q;
    logic   resp_valid_q;
    logic   busy_q;

    // Datapath state. acc_q holds {product} for multiply or
    // {remainder, quotient} for divide; opnd_q is the multiplicand or the
    // divisor magnitude, whichever the iteration needs each cycle.
    muldiv_funct3_t    op_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_d;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;
    logic [XLEN-1:0]   result_d;

    // Operand decode on the incoming request.
    muldiv_funct3_t    req_op;
    logic              rs1_signed;
    logic              rs2_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              is_div;
    logic              div_zero;
    logic              div_ovf;
    logic              fast_path;
    logic              neg_d;
    logic [2*XLEN-1:0] acc_init;
    logic [XLEN-1:0]   opnd_init;

    // Iteration and fixup intermediates.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN:0]   div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    logic              accept;
    logic              last_iter;

    assign accept    = bus.req_valid && req_ready_q && !bus.flush;
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.busy       = busy_q;
    assign bus.result     = result_q;

    // Decode the request: signedness, magnitudes, fast-path detection and
    // the initial accumulator image. Fast paths preload acc_q so that the
    // ordinary FIXUP selection (with no negation) yields the required value.
    always_comb begin
        // NOTE: every output of this block is assigned first, so no path
        // through the case statements can leave a value held (no latch).
        req_op     = muldiv_funct3_t'(bus.funct3);
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
        case (req_op)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                rs1_signed = 1'b1;
                rs2_signed = 1'b1;
            end
            F3_MULHSU: rs1_signed = 1'b1;
            default:   ;
        endcase

        a_neg  = rs1_signed && bus.rs1_data[XLEN-1];
        b_neg  = rs2_signed && bus.rs2_data[XLEN-1];
        a_mag  = a_neg ? (~bus.rs1_data + 1'b1) : bus.rs1_data;
        b_mag  = b_neg ? (~bus.rs2_data + 1'b1) : bus.rs2_data;
        is_div = bus.funct3[2];

        div_zero  = is_div && (bus.rs2_data == '0);
        div_ovf   = ((req_op == F3_DIV) || (req_op == F3_REM)) &&
                    (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (bus.rs2_data == '1);
        fast_path = div_zero || div_ovf;

        // Remainder follows the dividend; everything else follows sign XOR.
        neg_d = (req_op == F3_REM) ? a_neg : (a_neg ^ b_neg);

        opnd_init = is_div ? b_mag : a_mag;
        if (div_zero) begin
            acc_init = {bus.rs1_data, {XLEN{1'b1}}};
            neg_d    = 1'b0;
        end else if (div_ovf) begin
            acc_init = {{XLEN{1'b0}}, bus.rs1_data};
            neg_d    = 1'b0;
        end else if (is_div) begin
            acc_init = {{XLEN{1'b0}}, a_mag};
        end else begin
            acc_init = {{XLEN{1'b0}}, b_mag};
        end
    end

    // One radix-2 step: shift-add for multiply, shift-subtract-restore for
    // divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_shift = {acc_q, 1'b0};
        div_diff  = div_shift[2*XLEN:XLEN] - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (div_diff[XLEN]) begin
                acc_d = div_shift[2*XLEN-1:0];
            end else begin
                acc_d = {div_diff[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
            end
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign correction and half selection applied in FIXUP.
    always_comb begin
        prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo      = acc_q[XLEN-1:0];
        rem      = acc_q[2*XLEN-1:XLEN];
        case (op_q)
            F3_MUL:                       result_d = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result_d = neg_q ? (~quo + 1'b1) : quo;
            default:                      result_d = neg_q ? (~rem + 1'b1) : rem;
        endcase
    end

    // Control FSM: sequences IDLE -> CALC/FIXUP -> DONE with the handshake
    // outputs registered alongside the state; flush always returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else if (bus.flush) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q     <= fast_path ? S_FIXUP : S_CALC;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (last_iter) begin
                        state_q <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    state_q      <= S_DONE;
                    busy_q       <= 1'b0;
                    resp_valid_q <= 1'b1;
                end
                S_DONE: begin
                    if (bus.resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: latch operands on accept, iterate in CALC, register the
    // result in FIXUP. Inputs are ignored outside the accepting cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= F3_MUL;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (!bus.flush) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= req_op;
                        opnd_q <= opnd_init;
                        acc_q  <= acc_init;
                        neg_q  <= neg_d;
                        cnt_q  <= '0;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIXUP: result_q <= result_d;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit; one operation in flight.
- Implements all eight muldiv_funct3_t ops (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) with operand width XLEN.
- Sits beside the ALU in the execute stage. The pipeline issues through a valid/ready request, stalls while the unit is busy, and drains a held response.

Parameters:
- XLEN, 32: operand/result width; even, >= 4.
- CNT_W, $clog2(XLEN)+1: iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of any in-flight or held operation.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- funct3  in  3  muldiv_funct3_t op select.
- rs1_data  in  XLEN  operand A (multiplicand/dividend).
- rs2_data  in  XLEN  operand B (multiplier/divisor).
- resp_valid  out  1  result valid; high only in DONE.
- resp_ready  in  1  consumer takes result.
- result  out  XLEN  registered result.
- busy  out  1  high in CALC or FIXUP.

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE; counter, accumulators and result are cleared to 0.
  - Outputs: req_ready=1, resp_valid=0, busy=0.
  - Reset asserted mid-operation discards the operation with no response.
- States and transitions:
  - IDLE: accept when req_valid && req_ready && !flush. On accept, latch funct3, operand magnitudes and sign flags.
  - On accept, go to FIXUP directly for a division-by-zero or signed-overflow fast path. Otherwise go to CALC with counter=0.
  - CALC: one radix-2 iteration per cycle; counter increments each cycle; after iteration XLEN (counter==XLEN-1) go to FIXUP.
  - FIXUP: apply sign correction and select the high/low half; register result; go to DONE.
  - DONE: hold result and resp_valid until resp_ready; on resp_ready go to IDLE. A request is accepted no earlier than the next IDLE cycle; there is no same-cycle back-to-back accept.
- Latency, from the accepting edge to the first cycle with resp_valid high:
  - XLEN+2 cycles on the normal path.
  - 2 cycles on the fast path.
  - Independent of operand values otherwise.
- Multiply:
  - Shift-add on magnitudes into a 2*XLEN product.
  - Operand signedness: mul/mulh treat both signed; mulhsu treats rs1 signed and rs2 unsigned; mulhu treats both unsigned.
  - Negate the product in FIXUP when the operand signs differ (signed operands only).
  - Result: mul returns bits [XLEN-1:0]; the mulh variants return bits [2*XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes, producing quotient and remainder.
  - Quotient is negated when the signs differ (div only).
  - Remainder takes the sign of the dividend (rem only); the result is truncated toward zero.
- Divide by zero (divisor==0), fast path:
  - div/divu return all ones.
  - rem/remu return rs1.
- Signed overflow (div/rem, rs1 = most negative, rs2 = all ones), fast path:
  - div returns rs1.
  - rem returns 0.
  - divu/remu with the same operands take the normal path.
- flush:
  - From any state, go to IDLE on the next edge; resp_valid drops and no response is produced.
  - flush and req_valid in the same IDLE cycle: flush wins and the request is not accepted.
  - flush while in DONE discards the held result.
- Stability:
  - result is stable while resp_valid is high.
  - Input changes during CALC/FIXUP/DONE have no effect.

Test Plan:
- mul 7 x 0xFFFFFFFD -> 0xFFFFFFEB; mulh same operands -> 0xFFFFFFFF; mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. Each has resp_valid exactly 34 cycles after accept.
- div 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; rem same operands -> 0xFFFFFFFF; divu 0xFFFFFFF9 / 2 -> 0x7FFFFFFC; remu same operands -> 1. Latency 34.
- div 5 / 0 -> 0xFFFFFFFF; rem 5 / 0 -> 5; div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem same operands -> 0. Each has latency 2. divu 0x80000000 / 0xFFFFFFFF -> 0 with latency 34.
- Backpressure: hold resp_ready low for 5 cycles in DONE -> result, resp_valid=1 and req_ready=0 all held; the request presented in those cycles is not accepted until IDLE.
- Flush 10 cycles into CALC -> IDLE next cycle, no resp_valid ever; the next mul 3 x 4 returns 12 at latency 34. Flush with a simultaneous req_valid in IDLE -> nothing accepted.
- Drop rst_n asynchronously mid-CALC -> req_ready=1, busy=0, resp_valid=0 and result=0 immediately; operation lost.
